// File: rtl/mux_n_pipe.sv
// mux_n_pipe: N-input word selector feeding a 2-entry skid FIFO.
// Binary select (HotMode=0) or highest-set-bit hot select (HotMode=1).
// The selected word is captured on input handshake. Z is driven from the FIFO head.
module mux_n_pipe #(
  parameter int DataWidth = 32,
  parameter int NumInputs = 8,
  parameter int SelWidth  = 3,
  parameter int HotMode   = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [SelWidth-1:0]            S,
  input  logic [NumInputs-2:0]           H,
  input  logic [NumInputs*DataWidth-1:0] I,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DataWidth-1:0]           Z,
  output logic                           sel_err
);

  logic [DataWidth-1:0] sel_data;
  logic                 sel_bad;
  logic [DataWidth-1:0] mem [2];
  logic                 wptr;
  logic                 rptr;
  logic [1:0]           count;
  logic                 push;
  logic                 pop;

  // Only one of S/H is meaningful per build; fold both into a sink to keep the other quiet.
  logic unused_sel;
  assign unused_sel = ^{S, H};

  // Word selection. Binary mode flags selects with no matching input.
  always_comb begin
    sel_data = '0;
    sel_bad  = 1'b0;
    if (HotMode != 0) begin
      sel_data = I[0 +: DataWidth];
      for (int k = 0; k < NumInputs - 1; k++) begin
        if (H[k]) sel_data = I[(k+1)*DataWidth +: DataWidth];
      end
    end else begin
      sel_bad = 1'b1;
      for (int k = 0; k < NumInputs; k++) begin
        if (S == SelWidth'(k)) begin
          sel_data = I[k*DataWidth +: DataWidth];
          sel_bad  = 1'b0;
        end
      end
    end
  end

  assign in_ready  = rst_n & (count < 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign Z         = out_valid ? mem[rptr] : '0;

  // FIFO storage, pointers, occupancy and the sticky select-error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0]  <= '0;
      mem[1]  <= '0;
      wptr    <= 1'b0;
      rptr    <= 1'b0;
      count   <= 2'd0;
      sel_err <= 1'b0;
    end else begin
      if (push) begin
        mem[wptr] <= sel_data;
        wptr      <= ~wptr;
        if (sel_bad) sel_err <= 1'b1;
      end
      if (pop) rptr <= ~rptr;
      case (count)
        2'd0: if (push) count <= 2'd1;
        2'd1: begin
          if (push && !pop)      count <= 2'd2;
          else if (pop && !push) count <= 2'd0;
        end
        2'd2: if (pop) count <= 2'd1;
        default: count <= 2'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_n_pipe.sv
// Directed bench for mux_n_pipe: binary 8-input, binary 6-input and hot-select builds.
module tb_mux_n_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [8*32-1:0] i_all;

  logic        iv0, ir0, ov0, or0, se0;
  logic [2:0]  s0;
  logic [6:0]  h0;
  logic [31:0] z0;

  logic        iv1, ir1, ov1, or1, se1;
  logic [2:0]  s1;
  logic [4:0]  h1;
  logic [31:0] z1;

  logic        iv2, ir2, ov2, or2, se2;
  logic [2:0]  s2;
  logic [6:0]  h2;
  logic [31:0] z2;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mux_n_pipe #(.DataWidth(32), .NumInputs(8), .SelWidth(3), .HotMode(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .S(s0), .H(h0), .I(i_all),
    .out_valid(ov0), .out_ready(or0), .Z(z0), .sel_err(se0));

  mux_n_pipe #(.DataWidth(32), .NumInputs(6), .SelWidth(3), .HotMode(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .S(s1), .H(h1), .I(i_all[6*32-1:0]),
    .out_valid(ov1), .out_ready(or1), .Z(z1), .sel_err(se1));

  mux_n_pipe #(.DataWidth(32), .NumInputs(8), .SelWidth(3), .HotMode(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .S(s2), .H(h2), .I(i_all),
    .out_valid(ov2), .out_ready(or2), .Z(z2), .sel_err(se2));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_data(input logic [31:0] base);
    for (int k = 0; k < 8; k++) i_all[k*32 +: 32] = base + 32'(k);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    iv0 = 0; or0 = 0; s0 = 0; h0 = 0;
    iv1 = 0; or1 = 0; s1 = 0; h1 = 0;
    iv2 = 0; or2 = 0; s2 = 0; h2 = 0;
    set_data(32'h1000_0000);

    // reset state
    #12;
    check("rst_ov0", 32'(ov0), 32'd0);
    check("rst_ir0", 32'(ir0), 32'd0);
    check("rst_z0", z0, 32'd0);
    check("rst_se0", 32'(se0), 32'd0);
    check("rst_ir1", 32'(ir1), 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_ir0", 32'(ir0), 32'd1);

    // binary select, 8 inputs
    iv0 = 1; or0 = 1; s0 = 3'd5;
    tick();
    check("bin_ov", 32'(ov0), 32'd1);
    check("bin_z", z0, 32'h1000_0005);
    iv0 = 0;
    tick();
    check("bin_drain", 32'(ov0), 32'd0);

    // out-of-range select, 6 inputs
    iv1 = 1; or1 = 1; s1 = 3'd7;
    tick();
    check("oor_ov", 32'(ov1), 32'd1);
    check("oor_z", z1, 32'd0);
    check("oor_err", 32'(se1), 32'd1);
    s1 = 3'd2;
    tick();
    check("oor_next_z", z1, 32'h1000_0002);
    check("oor_sticky", 32'(se1), 32'd1);
    iv1 = 0;
    tick();
    check("oor_drain", 32'(ov1), 32'd0);
    check("oor_sticky2", 32'(se1), 32'd1);

    // hot select
    iv2 = 1; or2 = 1; h2 = 7'b0010110;
    tick();
    check("hot_z5", z2, 32'h1000_0005);
    h2 = 7'b0000000;
    tick();
    check("hot_z0", z2, 32'h1000_0000);
    h2 = 7'b1000001;
    tick();
    check("hot_z7", z2, 32'h1000_0007);
    iv2 = 0;
    tick();
    check("hot_err", 32'(se2), 32'd0);
    check("hot_drain", 32'(ov2), 32'd0);

    // backpressure: A, B accepted, C held
    or0 = 0; iv0 = 1; s0 = 3'd1;
    tick();
    check("bp_a_z", z0, 32'h1000_0001);
    check("bp_a_ir", 32'(ir0), 32'd1);
    s0 = 3'd2;
    tick();
    check("bp_b_ir", 32'(ir0), 32'd0);
    check("bp_b_z", z0, 32'h1000_0001);
    s0 = 3'd3;
    tick();
    check("bp_c_ir", 32'(ir0), 32'd0);
    check("bp_c_z", z0, 32'h1000_0001);
    check("bp_c_ov", 32'(ov0), 32'd1);
    or0 = 1;
    tick();
    check("bp_pop_a_z", z0, 32'h1000_0002);
    check("bp_pop_a_ov", 32'(ov0), 32'd1);
    check("bp_pop_a_ir", 32'(ir0), 32'd1);
    tick();
    check("bp_pop_b_z", z0, 32'h1000_0003);
    check("bp_pop_b_ov", 32'(ov0), 32'd1);
    iv0 = 0;
    tick();
    check("bp_empty", 32'(ov0), 32'd0);

    // streaming, one beat per cycle
    iv0 = 1; or0 = 1;
    for (int i = 0; i < 20; i++) begin
      s0 = 3'(i % 8);
      set_data(32'h2000_0000 + 32'(i * 16));
      tick();
      check("str_ov", 32'(ov0), 32'd1);
      check("str_ir", 32'(ir0), 32'd1);
      check("str_z", z0, 32'h2000_0000 + 32'(i * 16) + 32'(i % 8));
    end
    iv0 = 0;
    tick();
    check("str_drain", 32'(ov0), 32'd0);

    // reset with a full FIFO
    or0 = 0; iv0 = 1; s0 = 3'd0;
    set_data(32'h3000_0000);
    tick();
    tick();
    check("full_ir", 32'(ir0), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ov", 32'(ov0), 32'd0);
    check("mid_rst_z", z0, 32'd0);
    check("mid_rst_ir", 32'(ir0), 32'd0);
    check("mid_rst_se1", 32'(se1), 32'd0);
    iv0 = 0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel2_ir", 32'(ir0), 32'd1);
    check("rel2_ov", 32'(ov0), 32'd0);
    iv0 = 1; or0 = 1; s0 = 3'd6;
    set_data(32'h4000_0000);
    tick();
    check("post_rst_z", z0, 32'h4000_0006);
    check("post_rst_ov", 32'(ov0), 32'd1);
    iv0 = 0;
    tick();
    check("no_stale", 32'(ov0), 32'd0);
    tick();
    check("no_stale2", 32'(ov0), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
